// File: rtl/bitsparse_term_scheduler.sv
// Bit-sparse term scheduler: expands a sign-magnitude (A,B) pair into
// power-of-two partial-product terms and issues up to ROWS set bits of |A|
// per cycle. Each issued A-bit occupies one row of MAG_W lanes, one lane per
// bit of |B|. Lanes whose term is zero are flagged invalid, so the PE never
// spends a cycle on a zero bit of A.
module bitsparse_term_scheduler #(
  parameter int MAG_W = 7,
  parameter int ROWS  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [7:0]       IN_A,
  input  logic [7:0]       IN_B,
  output logic [15:0][2:0] AExps,
  output logic [15:0]      ASigns,
  output logic [15:0][2:0] BExps,
  output logic [15:0]      BSigns,
  output logic [15:0]      IsInvalidPair,
  output logic             OUT_VALID,
  output logic             OUT_LAST
);

  localparam int LANES = 16;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                  state_q, state_d;
  logic [MAG_W-1:0]        ra_q, ra_d;
  logic [MAG_W-1:0]        bm_q, bm_d;
  logic                    sa_q, sa_d;
  logic                    sb_q, sb_d;

  logic [LANES-1:0][2:0]   a_exps_q, a_exps_d;
  logic [LANES-1:0]        a_signs_q, a_signs_d;
  logic [LANES-1:0][2:0]   b_exps_q, b_exps_d;
  logic [LANES-1:0]        b_signs_q, b_signs_d;
  logic [LANES-1:0]        inv_q, inv_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;

  // Row selection results for the current EMIT cycle.
  logic [MAG_W-1:0]        ra_rem;
  logic [ROWS-1:0]         row_ok;
  logic [ROWS-1:0][2:0]    row_exp;
  logic                    accept;

  // Pick the ROWS lowest set bits of ra and compute what remains afterwards.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise synthesis infers a latch to hold its old value.
    ra_rem  = ra_q;
    row_ok  = '0;
    row_exp = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int i = 0; i < MAG_W; i++) begin
        if (!row_ok[r] && ra_rem[i]) begin
          row_ok[r]  = 1'b1;
          row_exp[r] = 3'(i);
          ra_rem[i]  = 1'b0;
        end
      end
    end
  end

  // Ready whenever the current cycle is idle or the final issue cycle of a pair;
  // depends on state only, never on IN_VALID.
  assign IN_READY = (state_q == IDLE) || (ra_rem == '0);
  assign accept   = IN_VALID && IN_READY;

  // Next-state, operand latch and next output group.
  always_comb begin
    state_d     = state_q;
    ra_d        = ra_q;
    bm_d        = bm_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    a_exps_d    = '0;
    a_signs_d   = '0;
    b_exps_d    = '0;
    b_signs_d   = '0;
    inv_d       = '1;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;

    if (state_q == EMIT) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int j = 0; j < MAG_W; j++) begin
          if (row_ok[r] && bm_q[j]) begin
            a_exps_d[r*MAG_W+j]  = row_exp[r];
            b_exps_d[r*MAG_W+j]  = 3'(j);
            a_signs_d[r*MAG_W+j] = sa_q;
            b_signs_d[r*MAG_W+j] = sb_q;
            inv_d[r*MAG_W+j]     = 1'b0;
          end
        end
      end
      out_valid_d = 1'b1;
      out_last_d  = (ra_rem == '0);
      ra_d        = ra_rem;
      if (ra_rem == '0) state_d = IDLE;
    end

    // A new pair overrides the drained state; a zero pair is dropped silently.
    if (accept) begin
      ra_d    = IN_A[MAG_W-1:0];
      bm_d    = IN_B[MAG_W-1:0];
      sa_d    = IN_A[7];
      sb_d    = IN_B[7];
      state_d = (|IN_A[MAG_W-1:0] && |IN_B[MAG_W-1:0]) ? EMIT : IDLE;
    end
  end

  // State and output registers; reset yields the bubble group.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge.
    if (RST) begin
      state_q     <= IDLE;
      ra_q        <= '0;
      bm_q        <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      a_exps_q    <= '0;
      a_signs_q   <= '0;
      b_exps_q    <= '0;
      b_signs_q   <= '0;
      inv_q       <= '1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      bm_q        <= bm_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      a_exps_q    <= a_exps_d;
      a_signs_q   <= a_signs_d;
      b_exps_q    <= b_exps_d;
      b_signs_q   <= b_signs_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign AExps         = a_exps_q;
  assign ASigns        = a_signs_q;
  assign BExps         = b_exps_q;
  assign BSigns        = b_signs_q;
  assign IsInvalidPair = inv_q;
  assign OUT_VALID     = out_valid_q;
  assign OUT_LAST      = out_last_q;

endmodule

// File: tb/tb_bitsparse_term_scheduler.sv
// Directed bench for bitsparse_term_scheduler: reset state, single and
// multi-cycle pairs, zero pair, back-to-back pairs and mid-pair reset.
module tb_bitsparse_term_scheduler;

  logic             CLK = 1'b0;
  logic             RST;
  logic             IN_VALID;
  logic             IN_READY;
  logic [7:0]       IN_A;
  logic [7:0]       IN_B;
  logic [15:0][2:0] AExps;
  logic [15:0]      ASigns;
  logic [15:0][2:0] BExps;
  logic [15:0]      BSigns;
  logic [15:0]      IsInvalidPair;
  logic             OUT_VALID;
  logic             OUT_LAST;

  int errors = 0;
  int checks = 0;

  bitsparse_term_scheduler dut (
    .CLK           (CLK),
    .RST           (RST),
    .IN_VALID      (IN_VALID),
    .IN_READY      (IN_READY),
    .IN_A          (IN_A),
    .IN_B          (IN_B),
    .AExps         (AExps),
    .ASigns        (ASigns),
    .BExps         (BExps),
    .BSigns        (BSigns),
    .IsInvalidPair (IsInvalidPair),
    .OUT_VALID     (OUT_VALID),
    .OUT_LAST      (OUT_LAST)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Signed sum of all valid-lane terms currently on the outputs.
  function automatic int term_sum();
    int s = 0;
    for (int i = 0; i < 16; i++) begin
      if (!IsInvalidPair[i]) begin
        if (ASigns[i] ^ BSigns[i]) s -= (1 << (AExps[i] + BExps[i]));
        else                       s += (1 << (AExps[i] + BExps[i]));
      end
    end
    return s;
  endfunction

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN_A = 8'h00; IN_B = 8'h00;
    @(negedge CLK);
    check("rst_mask",  32'(IsInvalidPair), 32'hFFFF);
    check("rst_valid", 32'(OUT_VALID), 32'd0);
    check("rst_last",  32'(OUT_LAST), 32'd0);
    check("rst_ready", 32'(IN_READY), 32'd1);
    check("rst_exps",  32'(AExps | BExps), 32'd0);
    check("rst_signs", 32'(ASigns | BSigns), 32'd0);
    RST = 1'b0;
    tick();

    // 1: +5 x -3, one group, lanes 0,1,7,8.
    IN_VALID = 1'b1; IN_A = 8'h05; IN_B = 8'h83;
    check("t1_ready_idle", 32'(IN_READY), 32'd1);
    tick();
    IN_VALID = 1'b0;
    check("t1_no_early_valid", 32'(OUT_VALID), 32'd0);
    check("t1_ready_final", 32'(IN_READY), 32'd1);
    tick();
    check("t1_mask",   32'(IsInvalidPair), 32'hFE7C);
    check("t1_valid",  32'(OUT_VALID), 32'd1);
    check("t1_last",   32'(OUT_LAST), 32'd1);
    check("t1_asigns", 32'(ASigns), 32'h0000);
    check("t1_bsigns", 32'(BSigns), 32'h0183);
    check("t1_aexp7",  32'(AExps[7]), 32'd2);
    check("t1_bexp8",  32'(BExps[8]), 32'd1);
    check("t1_sum",    32'(term_sum()), 32'(-15));
    tick();
    check("t1_bubble_mask",  32'(IsInvalidPair), 32'hFFFF);
    check("t1_bubble_valid", 32'(OUT_VALID), 32'd0);

    // 2: +127 x +1, four groups.
    IN_VALID = 1'b1; IN_A = 8'h7F; IN_B = 8'h01;
    tick();
    IN_VALID = 1'b0;
    check("t2_ready_c1", 32'(IN_READY), 32'd0);
    tick();
    check("t2_mask_g1", 32'(IsInvalidPair), 32'hFF7E);
    check("t2_last_g1", 32'(OUT_LAST), 32'd0);
    check("t2_aexp7_g1", 32'(AExps[7]), 32'd1);
    check("t2_ready_c2", 32'(IN_READY), 32'd0);
    tick();
    check("t2_mask_g2", 32'(IsInvalidPair), 32'hFF7E);
    check("t2_last_g2", 32'(OUT_LAST), 32'd0);
    check("t2_aexp0_g2", 32'(AExps[0]), 32'd2);
    check("t2_ready_c3", 32'(IN_READY), 32'd0);
    tick();
    check("t2_mask_g3", 32'(IsInvalidPair), 32'hFF7E);
    check("t2_last_g3", 32'(OUT_LAST), 32'd0);
    check("t2_aexp7_g3", 32'(AExps[7]), 32'd5);
    check("t2_ready_c4", 32'(IN_READY), 32'd1);
    tick();
    check("t2_mask_g4",  32'(IsInvalidPair), 32'hFFFE);
    check("t2_valid_g4", 32'(OUT_VALID), 32'd1);
    check("t2_last_g4",  32'(OUT_LAST), 32'd1);
    check("t2_aexp0_g4", 32'(AExps[0]), 32'd6);
    tick();
    check("t2_bubble_valid", 32'(OUT_VALID), 32'd0);

    // 3: -1 x -1.
    IN_VALID = 1'b1; IN_A = 8'h81; IN_B = 8'h81;
    tick();
    IN_VALID = 1'b0;
    tick();
    check("t3_mask",   32'(IsInvalidPair), 32'hFFFE);
    check("t3_exps",   32'({AExps[0], BExps[0]}), 32'd0);
    check("t3_asigns", 32'(ASigns), 32'h0001);
    check("t3_bsigns", 32'(BSigns), 32'h0001);
    check("t3_valid",  32'(OUT_VALID), 32'd1);
    check("t3_last",   32'(OUT_LAST), 32'd1);
    check("t3_sum",    32'(term_sum()), 32'd1);
    tick();

    // 4: zero A consumed silently.
    IN_VALID = 1'b1; IN_A = 8'h00; IN_B = 8'h05;
    tick();
    IN_VALID = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t4_ready", 32'(IN_READY), 32'd1);
      check("t4_valid", 32'(OUT_VALID), 32'd0);
      check("t4_mask",  32'(IsInvalidPair), 32'hFFFF);
      tick();
    end

    // 5: (+3,+1) then (+4,+2) with IN_VALID held; no bubble between pairs.
    IN_VALID = 1'b1; IN_A = 8'h03; IN_B = 8'h01;
    tick();
    IN_A = 8'h04; IN_B = 8'h02;
    check("t5_ready_last", 32'(IN_READY), 32'd1);
    tick();
    IN_VALID = 1'b0;
    check("t5_mask_p1",  32'(IsInvalidPair), 32'hFF7E);
    check("t5_valid_p1", 32'(OUT_VALID), 32'd1);
    check("t5_last_p1",  32'(OUT_LAST), 32'd1);
    check("t5_sum_p1",   32'(term_sum()), 32'd3);
    tick();
    check("t5_mask_p2",  32'(IsInvalidPair), 32'hFFFD);
    check("t5_valid_p2", 32'(OUT_VALID), 32'd1);
    check("t5_last_p2",  32'(OUT_LAST), 32'd1);
    check("t5_exps_p2",  32'({AExps[1], BExps[1]}), 32'({3'd2, 3'd1}));
    check("t5_sum_p2",   32'(term_sum()), 32'd8);
    tick();
    check("t5_bubble", 32'(OUT_VALID), 32'd0);

    // 6: reset pulsed during the second issue cycle of +127 x +1.
    IN_VALID = 1'b1; IN_A = 8'h7F; IN_B = 8'h01;
    tick();
    IN_VALID = 1'b0;
    tick();
    check("t6_pre_valid", 32'(OUT_VALID), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("t6_async_mask",  32'(IsInvalidPair), 32'hFFFF);
    check("t6_async_valid", 32'(OUT_VALID), 32'd0);
    check("t6_async_last",  32'(OUT_LAST), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    check("t6_ready_after", 32'(IN_READY), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_no_terms", 32'(OUT_VALID), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
